// File: rtl/mul_display_sequencer.sv
// rtl/mul_display_sequencer.sv - control FSM for the signed-multiply BCD display path
// Sequences multiplier clear/start/wait, BCD load and bounded one-digit scrolling.
module mul_display_sequencer #(
  parameter int WIDTH      = 8,
  parameter int TIMEOUT    = 2*WIDTH+4,
  parameter int NUM_DIGITS = 5,
  parameter int WINDOW     = 4,
  parameter int POS_W      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             scroll_l,
  input  logic             scroll_r,
  input  logic             is_neg1,
  input  logic             is_neg2,
  input  logic             mul_done,
  input  logic             prod_zero,
  output logic             mul_rst,
  output logic             mul_start,
  output logic             sr_load,
  output logic             sr_en,
  output logic             sr_dir,
  output logic             sign,
  output logic [POS_W-1:0] pos,
  output logic             busy,
  output logic             err
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [POS_W-1:0] POS_MAX  = POS_W'(NUM_DIGITS - WINDOW);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_START, S_WAIT, S_LOAD, S_SHOW
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             go_prev_q, l_prev_q, r_prev_q;
  logic             sign_q, sign_d;
  logic             err_q, err_d;
  logic             sr_en_q, sr_en_d;
  logic             sr_dir_q, sr_dir_d;
  logic             go_edge, l_edge, r_edge;

  assign go_edge = go & ~go_prev_q;
  assign l_edge  = scroll_l & ~l_prev_q;
  assign r_edge  = scroll_r & ~r_prev_q;

  // Edge registers reset high so a level already asserted at release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pos_q     <= '0;
      go_prev_q <= 1'b1;
      l_prev_q  <= 1'b1;
      r_prev_q  <= 1'b1;
      sign_q    <= 1'b0;
      err_q     <= 1'b0;
      sr_en_q   <= 1'b0;
      sr_dir_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      go_prev_q <= go;
      l_prev_q  <= scroll_l;
      r_prev_q  <= scroll_r;
      sign_q    <= sign_d;
      err_q     <= err_d;
      sr_en_q   <= sr_en_d;
      sr_dir_q  <= sr_dir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    sign_d   = sign_q;
    err_d    = err_q;
    sr_en_d  = 1'b0;
    sr_dir_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go_edge) begin
          state_d = S_CLR;
          sign_d  = is_neg1 ^ is_neg2;
          err_d   = 1'b0;
        end
      end
      S_CLR:   state_d = S_START;
      S_START: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // A done arriving on the last allowed cycle still counts as success.
        if (mul_done) begin
          state_d = S_LOAD;
          if (prod_zero) sign_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOAD: begin
        state_d = S_SHOW;
        pos_d   = '0;
      end
      S_SHOW: begin
        if (go_edge) begin
          state_d = S_CLR;
          sign_d  = is_neg1 ^ is_neg2;
          err_d   = 1'b0;
        end else if (l_edge && !r_edge && (pos_q < POS_MAX)) begin
          sr_en_d  = 1'b1;
          sr_dir_d = 1'b0;
          pos_d    = pos_q + 1'b1;
        end else if (r_edge && !l_edge && (pos_q != '0)) begin
          sr_en_d  = 1'b1;
          sr_dir_d = 1'b1;
          pos_d    = pos_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mul_rst   = (state_q == S_CLR);
  assign mul_start = (state_q == S_START);
  assign sr_load   = (state_q == S_LOAD);
  assign busy      = (state_q == S_CLR) || (state_q == S_START) ||
                     (state_q == S_WAIT) || (state_q == S_LOAD);
  assign sr_en     = sr_en_q;
  assign sr_dir    = sr_dir_q;
  assign sign      = sign_q;
  assign pos       = pos_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mul_display_sequencer.sv
// tb/tb_mul_display_sequencer.sv - self-checking bench for mul_display_sequencer
module tb_mul_display_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic go = 1'b1, scroll_l = 1'b0, scroll_r = 1'b0;
  logic is_neg1 = 1'b0, is_neg2 = 1'b0, mul_done = 1'b0, prod_zero = 1'b0;
  logic mul_rst, mul_start, sr_load, sr_en, sr_dir, sign, busy, err;
  logic [0:0] pos;

  int checks = 0;
  int errors = 0;

  mul_display_sequencer dut (
    .clk(clk), .rst_n(rst_n), .go(go), .scroll_l(scroll_l), .scroll_r(scroll_r),
    .is_neg1(is_neg1), .is_neg2(is_neg2), .mul_done(mul_done), .prod_zero(prod_zero),
    .mul_rst(mul_rst), .mul_start(mul_start), .sr_load(sr_load), .sr_en(sr_en),
    .sr_dir(sr_dir), .sign(sign), .pos(pos), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic neg1;
    logic neg2;
    logic pzero;
    int   done_cyc;
    logic exp_sign;
  } op_vec_t;

  typedef struct {
    logic l;
    logic r;
    logic exp_en;
    logic exp_dir;
    logic exp_pos;
  } scroll_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pulses(input string name, input logic [3:0] exp);
    chk(name, {28'd0, mul_rst, mul_start, sr_load, sr_en}, {28'd0, exp});
  endtask

  // Go edge at cycle 0, done at done_cyc, ends in SHOW at done_cyc+2.
  task automatic run_op(input op_vec_t v, input int idx);
    is_neg1 = v.neg1;
    is_neg2 = v.neg2;
    go = 1'b1;
    tick();
    go = 1'b0;
    chk($sformatf("op%0d_mul_rst@1", idx), {28'd0, mul_rst, mul_start, sr_load, sr_en}, 32'h8);
    tick();
    chk($sformatf("op%0d_mul_start@2", idx), {28'd0, mul_rst, mul_start, sr_load, sr_en}, 32'h4);
    tick();
    for (int c = 3; c < v.done_cyc; c++) begin
      chk($sformatf("op%0d_wait_busy_c%0d", idx, c), {30'd0, busy, sr_load}, 32'h2);
      tick();
    end
    mul_done = 1'b1;
    prod_zero = v.pzero;
    tick();
    mul_done = 1'b0;
    prod_zero = 1'b0;
    chk($sformatf("op%0d_sr_load", idx), {27'd0, mul_rst, mul_start, sr_load, sr_en, busy}, 32'h5);
    tick();
    chk($sformatf("op%0d_show_busy", idx), {31'd0, busy}, 32'd0);
    chk($sformatf("op%0d_sign", idx), {31'd0, sign}, {31'd0, v.exp_sign});
    chk($sformatf("op%0d_pos", idx), {31'd0, pos}, 32'd0);
    chk($sformatf("op%0d_err", idx), {31'd0, err}, 32'd0);
  endtask

  op_vec_t     ops[6];
  scroll_vec_t scr[8];

  initial begin
    ops[0] = '{1'b1, 1'b0, 1'b0, 12, 1'b1};
    ops[1] = '{1'b1, 1'b0, 1'b1, 12, 1'b0};
    ops[2] = '{1'b0, 1'b0, 1'b0, 3,  1'b0};
    ops[3] = '{1'b1, 1'b1, 1'b0, 5,  1'b0};
    ops[4] = '{1'b0, 1'b1, 1'b0, 20, 1'b1};
    ops[5] = '{1'b0, 1'b1, 1'b0, 22, 1'b1};

    scr[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    scr[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    scr[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    scr[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    scr[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    scr[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    scr[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    scr[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset with go held high: no edge at release.
    tick();
    tick();
    chk("reset_outputs", {23'd0, mul_rst, mul_start, sr_load, sr_en, sr_dir, sign, pos, busy, err}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_reset_idle%0d", i), {27'd0, mul_rst, mul_start, sr_load, sr_en, busy}, 32'd0);
    end
    go = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], i);
      tick();
    end

    // Timeout: WAIT entered at cycle 3, IDLE with err at cycle 23.
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    for (int c = 3; c <= 22; c++) begin
      chk($sformatf("to_wait_c%0d", c), {29'd0, busy, sr_load, err}, 32'h4);
      tick();
    end
    chk("to_idle_err", {28'd0, busy, sr_load, err, mul_start}, 32'h2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("to_no_load%0d", i), {29'd0, busy, sr_load, err}, 32'h1);
    end
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("to_go_clears_err", {30'd0, mul_rst, err}, 32'h2);
    tick();
    tick();
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    tick();
    chk("to_recover_show", {30'd0, busy, pos}, 32'd0);

    // Scroll table, starting in SHOW at pos 0.
    for (int i = 0; i < 8; i++) begin
      scroll_l = scr[i].l;
      scroll_r = scr[i].r;
      tick();
      scroll_l = 1'b0;
      scroll_r = 1'b0;
      chk($sformatf("scr%0d_en", i), {31'd0, sr_en}, {31'd0, scr[i].exp_en});
      if (scr[i].exp_en)
        chk($sformatf("scr%0d_dir", i), {31'd0, sr_dir}, {31'd0, scr[i].exp_dir});
      chk($sformatf("scr%0d_pos", i), {31'd0, pos}, {31'd0, scr[i].exp_pos});
      tick();
      chk($sformatf("scr%0d_en_single", i), {30'd0, sr_en, busy}, 32'd0);
    end

    // go and scroll_l together in SHOW: CLR wins, no step.
    go = 1'b1;
    scroll_l = 1'b1;
    tick();
    go = 1'b0;
    scroll_l = 1'b0;
    chk("go_vs_scroll", {28'd0, mul_rst, sr_en, busy, pos}, 32'ha);
    tick();
    chk("go_vs_scroll_start", {31'd0, mul_start}, 32'd1);
    tick();
    // go edge during WAIT is ignored.
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("wait_go_ignored%0d", i), {29'd0, mul_rst, mul_start, busy}, 32'd1);
      tick();
    end
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    chk("wait_go_load", {31'd0, sr_load}, 32'd1);
    tick();
    chk("wait_go_show", {31'd0, busy}, 32'd0);

    // Reset mid-operation drops straight to IDLE.
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {23'd0, mul_rst, mul_start, sr_load, sr_en, sr_dir, sign, pos, busy, err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midreset_idle", {29'd0, mul_rst, mul_start, busy}, 32'd0);
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("midreset_next_clr", {30'd0, mul_rst, mul_start}, 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
